// File: rtl/md_issue_pkg.sv
// md_issue_pkg: shared HILO operation codes, engine request encoding and
// FSM state encoding for the multiply/divide issue controller.
package md_issue_pkg;

  localparam int HILO_CODE_W = 5;

  localparam logic [HILO_CODE_W-1:0] HILO_NONE  = 5'd0;
  localparam logic [HILO_CODE_W-1:0] HILO_MULT  = 5'd1;
  localparam logic [HILO_CODE_W-1:0] HILO_MULTU = 5'd2;
  localparam logic [HILO_CODE_W-1:0] HILO_DIV   = 5'd3;
  localparam logic [HILO_CODE_W-1:0] HILO_DIVU  = 5'd4;
  localparam logic [HILO_CODE_W-1:0] HILO_MTHI  = 5'd5;
  localparam logic [HILO_CODE_W-1:0] HILO_MTLO  = 5'd6;
  localparam logic [HILO_CODE_W-1:0] HILO_MFHI  = 5'd7;
  localparam logic [HILO_CODE_W-1:0] HILO_MFLO  = 5'd8;

  typedef enum logic [1:0] {
    REQ_MULT  = 2'd0,
    REQ_MULTU = 2'd1,
    REQ_DIV   = 2'd2,
    REQ_DIVU  = 2'd3
  } req_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } md_state_e;

  // Map a HILO arithmetic code onto the engine request encoding.
  function automatic req_op_e hilo_to_req(input logic [HILO_CODE_W-1:0] code);
    req_op_e op;
    case (code)
      HILO_MULTU: op = REQ_MULTU;
      HILO_DIV:   op = REQ_DIV;
      HILO_DIVU:  op = REQ_DIVU;
      default:    op = REQ_MULT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/md_issue_watchdog.sv
// md_issue_watchdog: counts cycles spent with an operation in flight and
// raises a sticky error (plus a one-cycle abort) when TIMEOUT is reached.
// Only instantiated when MD_ISSUE_TIMEOUT_EN is defined.
module md_issue_watchdog #(
  parameter int TIMEOUT = 63
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic expire,
  output logic timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Count while active; expire on the TIMEOUT-th active cycle and latch the error.
  always_comb begin
    cnt_d  = '0;
    err_d  = err_q;
    expire = 1'b0;
    if (active) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        expire = 1'b1;
        err_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and sticky flag registers; reset is active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage initiator for the multiply/divide engine. Owns HI/LO,
// issues mult/div requests over valid/ready, waits for the response pulse and
// stalls D while any HILO op is in flight. Optional watchdog: MD_ISSUE_TIMEOUT_EN.
module md_issue_ctrl
  import md_issue_pkg::*;
#(
  parameter int TYPE_W  = 5,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              e_valid,
  input  logic [TYPE_W-1:0] e_type,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  input  logic              d_uses_hilo,
  output logic              stall_d,
  output logic              busy,
  output logic              req_valid,
  output logic [1:0]        req_op,
  output logic [31:0]       req_a,
  output logic [31:0]       req_b,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_hi,
  input  logic [31:0]       rsp_lo,
  output logic [31:0]       rd_data,
  output logic              timeout_err
);

  md_state_e                state_q, state_d;
  logic [31:0]              hi_q, hi_d;
  logic [31:0]              lo_q, lo_d;
  logic [31:0]              req_a_q, req_a_d;
  logic [31:0]              req_b_q, req_b_d;
  req_op_e                  req_op_q, req_op_d;
  logic [HILO_CODE_W-1:0]   op_code;
  logic                     is_md_op;
  logic                     start;
  logic                     wd_expire;

  assign op_code  = HILO_CODE_W'(e_type);
  assign is_md_op = (op_code == HILO_MULT) || (op_code == HILO_MULTU) ||
                    (op_code == HILO_DIV)  || (op_code == HILO_DIVU);
  assign start    = (state_q == ST_IDLE) && e_valid && is_md_op;

`ifdef MD_ISSUE_TIMEOUT_EN
  md_issue_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .active      (state_q != ST_IDLE),
    .expire      (wd_expire),
    .timeout_err (timeout_err)
  );
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state, request payload capture and HI/LO update; a watchdog abort wins.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    req_a_d  = req_a_q;
    req_b_d  = req_b_q;
    req_op_d = req_op_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          req_a_d  = rs_val;
          req_b_d  = rt_val;
          req_op_d = hilo_to_req(op_code);
          state_d  = ST_REQ;
        end else if (e_valid && (op_code == HILO_MTHI)) begin
          hi_d = rs_val;
        end else if (e_valid && (op_code == HILO_MTLO)) begin
          lo_d = rs_val;
        end
      end
      ST_REQ: begin
        if (req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rsp_valid) begin
          hi_d    = rsp_hi;
          lo_d    = rsp_lo;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (wd_expire) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State, HI/LO and request registers; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      req_a_q  <= '0;
      req_b_q  <= '0;
      req_op_q <= REQ_MULT;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      req_a_q  <= req_a_d;
      req_b_q  <= req_b_d;
      req_op_q <= req_op_d;
    end
  end

  // mfhi/mflo read path, zero for every other E-stage code.
  always_comb begin
    rd_data = '0;
    if (op_code == HILO_MFHI) begin
      rd_data = hi_q;
    end else if (op_code == HILO_MFLO) begin
      rd_data = lo_q;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign req_valid = (state_q == ST_REQ);
  assign stall_d   = d_uses_hilo && (busy || start);
  assign req_op    = req_op_q;
  assign req_a     = req_a_q;
  assign req_b     = req_b_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed bench for md_issue_ctrl with an engine model and
// scoreboard queues for request payloads, engine results and mf* reads.
// Watchdog section only runs when MD_ISSUE_TIMEOUT_EN is defined.
module tb_md_issue_ctrl;
  import md_issue_pkg::*;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  logic        clk;
  logic        reset;
  logic        e_valid;
  logic [4:0]  e_type;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_hilo;
  logic        stall_d;
  logic        busy;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic [31:0] rd_data;
  logic        timeout_err;

  int          total;
  int          bad;
  req_t        req_q[$];
  logic [63:0] rsp_q[$];
  logic [31:0] rd_q[$];
  req_t        cur_req;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_issue_ctrl #(
    .TYPE_W  (5),
    .TIMEOUT (63)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .e_valid     (e_valid),
    .e_type      (e_type),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .d_uses_hilo (d_uses_hilo),
    .stall_d     (stall_d),
    .busy        (busy),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_hi      (rsp_hi),
    .rsp_lo      (rsp_lo),
    .rd_data     (rd_data),
    .timeout_err (timeout_err)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Engine reference: {hi, lo} for each arithmetic op (div: hi=rem, lo=quot).
  function automatic logic [63:0] engineModel(input logic [4:0] code,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic [63:0]        r;
    r = '0;
    case (code)
      HILO_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r  = sp;
      end
      HILO_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        r  = up;
      end
      HILO_DIV: begin
        if (b != 0) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
      HILO_DIVU: begin
        if (b != 0) r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the E/D stage inputs and record what the scoreboard should expect.
  task automatic applyStimulus(input logic v, input logic [4:0] t,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic d);
    req_t r;
    e_valid     = v;
    e_type      = t;
    rs_val      = rs;
    rt_val      = rt;
    d_uses_hilo = d;
    if (v) begin
      case (t)
        HILO_MULT, HILO_MULTU, HILO_DIV, HILO_DIVU: begin
          r.op = 2'(t - HILO_MULT);
          r.a  = rs;
          r.b  = rt;
          req_q.push_back(r);
          rsp_q.push_back(engineModel(t, rs, rt));
        end
        HILO_MTHI: exp_hi = rs;
        HILO_MTLO: exp_lo = rs;
        HILO_MFHI: rd_q.push_back(exp_hi);
        HILO_MFLO: rd_q.push_back(exp_lo);
        default: ;
      endcase
    end
  endtask

  task automatic checkReq();
    if (req_q.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL req_sb observed=empty expected=entry");
    end else begin
      cur_req = req_q.pop_front();
      checkOutput("req_valid", 32'(req_valid), 32'd1);
      checkOutput("req_op", 32'(req_op), 32'(cur_req.op));
      checkOutput("req_a", req_a, cur_req.a);
      checkOutput("req_b", req_b, cur_req.b);
    end
  endtask

  task automatic checkRd(input string tag);
    if (rd_q.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s observed=empty expected=entry", tag);
    end else begin
      checkOutput(tag, rd_data, rd_q.pop_front());
    end
  endtask

  // Engine response pulse from the model queue; HI/LO model follows at the edge.
  task automatic driveRsp();
    logic [63:0] r;
    r = rsp_q.pop_front();
    rsp_valid = 1'b1;
    rsp_hi    = r[63:32];
    rsp_lo    = r[31:0];
    exp_hi    = r[63:32];
    exp_lo    = r[31:0];
  endtask

  // The stall must keep every HILO op out of E while an operation is in flight.
  always @(negedge clk) begin
    if (reset && busy) begin
      assert (!(e_valid && (e_type != HILO_NONE)))
      else begin
        bad++;
        $error("[TB] FAIL hilo_in_e_while_busy observed=%0d expected=0", e_type);
      end
    end
  end

  initial begin
    int n;
    total       = 0;
    bad         = 0;
    exp_hi      = '0;
    exp_lo      = '0;
    reset       = 1'b0;
    e_valid     = 1'b0;
    e_type      = HILO_NONE;
    rs_val      = '0;
    rt_val      = '0;
    d_uses_hilo = 1'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_hi      = '0;
    rsp_lo      = '0;

    // Reset state
    tick();
    tick();
    sample();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_req_valid", 32'(req_valid), 32'd0);
    checkOutput("rst_stall", 32'(stall_d), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
    checkOutput("rst_req_op", 32'(req_op), 32'd0);
    checkOutput("rst_req_a", req_a, 32'd0);
    checkOutput("rst_req_b", req_b, 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    tick();
    reset = 1'b1;

    // mult with immediate handshake
    applyStimulus(1'b1, HILO_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
    sample();
    checkOutput("mult_stall_on_start", 32'(stall_d), 32'd1);
    checkOutput("mult_busy_t0", 32'(busy), 32'd0);
    tick();
    applyStimulus(1'b0, HILO_NONE, 32'd0, 32'd0, 1'b0);
    req_ready = 1'b1;
    sample();
    checkOutput("mult_busy_t1", 32'(busy), 32'd1);
    checkReq();
    tick();
    req_ready = 1'b0;
    driveRsp();
    sample();
    checkOutput("mult_busy_t2", 32'(busy), 32'd1);
    checkOutput("mult_req_valid_wait", 32'(req_valid), 32'd0);
    tick();
    rsp_valid = 1'b0;
    applyStimulus(1'b1, HILO_MFHI, 32'd0, 32'd0, 1'b0);
    sample();
    checkOutput("mult_busy_t3", 32'(busy), 32'd0);
    checkRd("mult_hi");
    tick();
    applyStimulus(1'b1, HILO_MFLO, 32'd0, 32'd0, 1'b0);
    sample();
    checkRd("mult_lo");

    // divu under backpressure, with D-stage stall checks during WAIT
    tick();
    applyStimulus(1'b1, HILO_DIVU, 32'd7, 32'd2, 1'b0);
    sample();
    checkOutput("divu_no_stall_no_d", 32'(stall_d), 32'd0);
    tick();
    applyStimulus(1'b0, HILO_NONE, 32'd0, 32'd0, 1'b0);
    sample();
    checkReq();
    for (int i = 1; i < 4; i++) begin
      tick();
      sample();
      checkOutput("divu_bp_valid", 32'(req_valid), 32'd1);
      checkOutput("divu_bp_op", 32'(req_op), 32'(cur_req.op));
      checkOutput("divu_bp_a", req_a, cur_req.a);
      checkOutput("divu_bp_b", req_b, cur_req.b);
    end
    tick();
    req_ready = 1'b1;
    sample();
    checkOutput("divu_valid_at_accept", 32'(req_valid), 32'd1);
    tick();
    req_ready   = 1'b0;
    d_uses_hilo = 1'b1;
    sample();
    checkOutput("wait_stall_mflo_in_d", 32'(stall_d), 32'd1);
    checkOutput("wait_req_valid", 32'(req_valid), 32'd0);
    tick();
    d_uses_hilo = 1'b0;
    sample();
    checkOutput("wait_no_stall_add_in_d", 32'(stall_d), 32'd0);
    tick();
    d_uses_hilo = 1'b1;
    driveRsp();
    sample();
    checkOutput("rsp_cycle_stall", 32'(stall_d), 32'd1);
    tick();
    rsp_valid = 1'b0;
    applyStimulus(1'b1, HILO_MFLO, 32'd0, 32'd0, 1'b1);
    sample();
    checkOutput("after_rsp_stall", 32'(stall_d), 32'd0);
    checkRd("divu_lo");

    // req_ready without req_valid
    tick();
    applyStimulus(1'b0, HILO_NONE, 32'd0, 32'd0, 1'b0);
    req_ready = 1'b1;
    sample();
    checkOutput("stray_ready_valid", 32'(req_valid), 32'd0);
    tick();
    req_ready = 1'b0;
    sample();
    checkOutput("stray_ready_busy", 32'(busy), 32'd0);

    // Local moves
    tick();
    applyStimulus(1'b1, HILO_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    sample();
    checkOutput("mthi_no_req", 32'(req_valid), 32'd0);
    tick();
    applyStimulus(1'b1, HILO_MFHI, 32'd0, 32'd0, 1'b0);
    sample();
    checkRd("mthi_readback");
    checkOutput("mthi_busy", 32'(busy), 32'd0);
    tick();
    applyStimulus(1'b1, HILO_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b1, HILO_MFLO, 32'd0, 32'd0, 1'b0);
    sample();
    checkRd("mtlo_readback");

    // Response pulse in IDLE is ignored
    tick();
    applyStimulus(1'b0, HILO_NONE, 32'd0, 32'd0, 1'b0);
    rsp_valid = 1'b1;
    rsp_hi    = 32'hAAAA_AAAA;
    rsp_lo    = 32'h5555_5555;
    tick();
    rsp_valid = 1'b0;
    applyStimulus(1'b1, HILO_MFHI, 32'd0, 32'd0, 1'b0);
    sample();
    checkRd("idle_rsp_ignored");

    // Reset during WAIT, then a late response
    tick();
    applyStimulus(1'b1, HILO_MULT, 32'd5, 32'd5, 1'b0);
    tick();
    applyStimulus(1'b0, HILO_NONE, 32'd0, 32'd0, 1'b0);
    req_ready = 1'b1;
    sample();
    checkReq();
    tick();
    req_ready = 1'b0;
    sample();
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    void'(rsp_q.pop_front());
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    #1;
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_valid", 32'(req_valid), 32'd0);
    tick();
    reset     = 1'b1;
    rsp_valid = 1'b1;
    rsp_hi    = 32'd5;
    rsp_lo    = 32'd6;
    tick();
    rsp_valid = 1'b0;
    applyStimulus(1'b1, HILO_MFHI, 32'd0, 32'd0, 1'b0);
    sample();
    checkOutput("late_rsp_busy", 32'(busy), 32'd0);
    checkRd("late_rsp_hi");
    tick();
    applyStimulus(1'b1, HILO_MFLO, 32'd0, 32'd0, 1'b0);
    sample();
    checkRd("late_rsp_lo");

`ifdef MD_ISSUE_TIMEOUT_EN
    // Watchdog: engine never accepts
    tick();
    applyStimulus(1'b1, HILO_MULT, 32'd9, 32'd9, 1'b0);
    tick();
    applyStimulus(1'b0, HILO_NONE, 32'd0, 32'd0, 1'b0);
    void'(req_q.pop_front());
    void'(rsp_q.pop_front());
    n = 0;
    while (!timeout_err && n < 200) begin
      tick();
      n++;
    end
    checkOutput("wd_cycles", 32'(n), 32'd63);
    checkOutput("wd_err", 32'(timeout_err), 32'd1);
    checkOutput("wd_req_valid", 32'(req_valid), 32'd0);
    checkOutput("wd_busy", 32'(busy), 32'd0);
    applyStimulus(1'b1, HILO_MFHI, 32'd0, 32'd0, 1'b0);
    sample();
    checkRd("wd_hi_kept");
    tick();
    sample();
    checkOutput("wd_err_sticky", 32'(timeout_err), 32'd1);
`else
    n = 0;
    tick();
    sample();
    checkOutput("no_wd_err", 32'(timeout_err), 32'd0);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
